heap_pq: RTL and testbench

//  Parametrised binary-heap priority queue with a valid/ready command port.

---
 rtl/heap_pq.sv | 217 +++++++++++++++++++++
 tb/tb_heap_pq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_pq.sv
// heap_pq: parametrised binary-heap priority queue (max- or min-ordered) with a
// valid/ready command port; sift-up and sift-down walk one heap level per cycle.
module heap_pq #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int MIN_HEAP = 0,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_key,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_key,
    output logic              top_valid,
    output logic [DATA_W-1:0] top_key,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = CNT_W + 1;

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SIFT_UP   = 2'd1,
        SIFT_DOWN = 2'd2
    } state_t;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MIN_HEAP != 0) better = (a < b);
        else               better = (a > b);
    endfunction

    logic [DATA_W-1:0] arr_r [DEPTH];
    state_t            state_r, state_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [AW-1:0]     idx_r, idx_s;
    logic [DATA_W-1:0] out_key_r, out_key_s;
    logic              out_valid_r, out_valid_s;
    logic              err_r, err_s;

    logic              wa_en_s, wb_en_s;
    logic [AW-1:0]     wa_addr_s, wb_addr_s;
    logic [DATA_W-1:0] wa_data_s, wb_data_s;

    logic [IW-1:0]     idx_w_s, cnt_w_s, l_s, r_s;
    logic [AW-1:0]     p_s, c_s;
    logic              l_ok_s, r_ok_s;
    logic [DATA_W-1:0] key_i_s, key_l_s, key_r_s, key_p_s, key_c_s;

    // Neighbour indices and keys of the current node; widened so children never wrap
    always_comb begin
        idx_w_s = IW'(idx_r);
        cnt_w_s = IW'(count_r);
        l_s     = (idx_w_s << 1) + IW'(1);
        r_s     = (idx_w_s << 1) + IW'(2);
        p_s     = AW'((idx_w_s - IW'(1)) >> 1);
        l_ok_s  = (l_s < cnt_w_s);
        r_ok_s  = (r_s < cnt_w_s);
        key_i_s = arr_r[idx_r];
        key_l_s = arr_r[AW'(l_s)];
        key_r_s = arr_r[AW'(r_s)];
        key_p_s = arr_r[p_s];
        // Right child only wins when strictly better, so ties keep the left child
        if (r_ok_s && better(key_r_s, key_l_s)) begin
            c_s     = AW'(r_s);
            key_c_s = key_r_s;
        end else begin
            c_s     = AW'(l_s);
            key_c_s = key_l_s;
        end
    end

    // Command decode and sift control; array writes leave through two write ports
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        idx_s       = idx_r;
        out_key_s   = out_key_r;
        out_valid_s = 1'b0;
        err_s       = 1'b0;
        wa_en_s     = 1'b0;
        wa_addr_s   = '0;
        wa_data_s   = cmd_key;
        wb_en_s     = 1'b0;
        wb_addr_s   = '0;
        wb_data_s   = key_i_s;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (count_r == CNT_W'(DEPTH)) begin
                                err_s = 1'b1;
                            end else begin
                                wa_en_s   = 1'b1;
                                wa_addr_s = AW'(count_r);
                                wa_data_s = cmd_key;
                                count_s   = count_r + CNT_W'(1);
                                idx_s     = AW'(count_r);
                                state_s   = (count_r != '0) ? SIFT_UP : IDLE;
                            end
                        end
                        OP_POP: begin
                            if (count_r == '0) begin
                                err_s = 1'b1;
                            end else begin
                                out_key_s   = arr_r[0];
                                out_valid_s = 1'b1;
                                wa_en_s     = 1'b1;
                                wa_addr_s   = '0;
                                wa_data_s   = arr_r[AW'(count_r - CNT_W'(1))];
                                count_s     = count_r - CNT_W'(1);
                                idx_s       = '0;
                                state_s     = (count_r > CNT_W'(2)) ? SIFT_DOWN : IDLE;
                            end
                        end
                        OP_REPLACE: begin
                            if (count_r == '0) begin
                                err_s = 1'b1;
                            end else begin
                                out_key_s   = arr_r[0];
                                out_valid_s = 1'b1;
                                wa_en_s     = 1'b1;
                                wa_addr_s   = '0;
                                wa_data_s   = cmd_key;
                                idx_s       = '0;
                                state_s     = (count_r > CNT_W'(1)) ? SIFT_DOWN : IDLE;
                            end
                        end
                        OP_CLEAR: begin
                            count_s = '0;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SIFT_UP: begin
                if ((idx_r != '0) && better(key_i_s, key_p_s)) begin
                    wa_en_s   = 1'b1;
                    wa_addr_s = idx_r;
                    wa_data_s = key_p_s;
                    wb_en_s   = 1'b1;
                    wb_addr_s = p_s;
                    wb_data_s = key_i_s;
                    idx_s     = p_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SIFT_DOWN: begin
                if (l_ok_s && better(key_c_s, key_i_s)) begin
                    wa_en_s   = 1'b1;
                    wa_addr_s = idx_r;
                    wa_data_s = key_c_s;
                    wb_en_s   = 1'b1;
                    wb_addr_s = c_s;
                    wb_data_s = key_i_s;
                    idx_s     = c_s;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, entry count and the registered result/error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= '0;
            idx_r       <= '0;
            out_key_r   <= '0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            idx_r       <= idx_s;
            out_key_r   <= out_key_s;
            out_valid_r <= out_valid_s;
            err_r       <= err_s;
        end
    end

    // Heap storage (not reset); a swap uses both ports in the same cycle
    always_ff @(posedge clk) begin
        if (wa_en_s) arr_r[wa_addr_s] <= wa_data_s;
        if (wb_en_s) arr_r[wb_addr_s] <= wb_data_s;
    end

    assign cmd_ready = (state_r == IDLE);
    assign top_valid = (count_r != '0) && (state_r == IDLE);
    assign top_key   = arr_r[0];
    assign count     = count_r;
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign out_valid = out_valid_r;
    assign out_key   = out_key_r;
    assign err       = err_r;
endmodule

// File: tb/tb_heap_pq.sv
// tb_heap_pq: table-driven directed vectors plus a randomised list model for heap_pq,
// using a max heap (DEPTH 7), a min heap (DEPTH 7) and a small max heap (DEPTH 4).
module tb_heap_pq;
    localparam int W = 8;
    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] REPL = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    logic [1:0]        cmd_op;
    logic [W-1:0]      cmd_key;
    logic [2:0]        cmd_valid_v, cmd_ready_v, out_valid_v, top_valid_v, full_v, empty_v, err_v;
    logic [2:0][W-1:0] out_key_v, top_key_v;
    logic [2:0][2:0]   count_v;

    always #5 clk = ~clk;

    heap_pq #(.DATA_W(W), .DEPTH(7), .MIN_HEAP(0)) u_max (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .out_valid(out_valid_v[0]), .out_key(out_key_v[0]),
        .top_valid(top_valid_v[0]), .top_key(top_key_v[0]), .count(count_v[0]),
        .full(full_v[0]), .empty(empty_v[0]), .err(err_v[0]));
    heap_pq #(.DATA_W(W), .DEPTH(7), .MIN_HEAP(1)) u_min (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .out_valid(out_valid_v[1]), .out_key(out_key_v[1]),
        .top_valid(top_valid_v[1]), .top_key(top_key_v[1]), .count(count_v[1]),
        .full(full_v[1]), .empty(empty_v[1]), .err(err_v[1]));
    heap_pq #(.DATA_W(W), .DEPTH(4), .MIN_HEAP(0)) u_small (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_v[2]), .cmd_ready(cmd_ready_v[2]),
        .cmd_op(cmd_op), .cmd_key(cmd_key), .out_valid(out_valid_v[2]), .out_key(out_key_v[2]),
        .top_valid(top_valid_v[2]), .top_key(top_key_v[2]), .count(count_v[2]),
        .full(full_v[2]), .empty(empty_v[2]), .err(err_v[2]));

    typedef struct {
        logic         is_err;
        logic [W-1:0] key;
    } exp_t;

    typedef struct {
        int           dut;
        logic [1:0]   op;
        logic [W-1:0] key;
        logic         has_out;
        logic [W-1:0] out;
        logic         is_err;
        int           cnt;
        logic [W-1:0] top;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   sel      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (dut %0d): got %0d expected %0d", name, sel, act, exp);
        end
    endtask

    function automatic bit tb_better(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
        return (d == 1) ? (a < b) : (a > b);
    endfunction

    function automatic int best_idx(input int d, input logic [W-1:0] m[$]);
        int b = -1;
        for (int i = 0; i < m.size(); i++)
            if (b < 0 || tb_better(d, m[i], m[b])) b = i;
        return b;
    endfunction

    function automatic logic [W-1:0] arr_at(input int d, input int i);
        if (d == 1) return u_min.arr_r[3'(i)];
        else        return u_max.arr_r[3'(i)];
    endfunction

    function automatic vec_t mk(input int d, input logic [1:0] op, input logic [W-1:0] key,
                                input logic ho, input logic [W-1:0] o, input logic ie,
                                input int cnt, input logic [W-1:0] top);
        vec_t v;
        v.dut = d; v.op = op; v.key = key; v.has_out = ho; v.out = o;
        v.is_err = ie; v.cnt = cnt; v.top = top;
        return v;
    endfunction

    // Scoreboard: every result or error pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && (out_valid_v[sel] || err_v[sel])) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output (dut %0d): out_valid=%0b err=%0b expected none",
                         sel, out_valid_v[sel], err_v[sel]);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_err", int'(err_v[sel]), int'(mon_e.is_err));
                check("sb_out_valid", int'(out_valid_v[sel]), int'(!mon_e.is_err));
                if (!mon_e.is_err) check("sb_out_key", int'(out_key_v[sel]), int'(mon_e.key));
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] key, input logic ho,
                         input logic [W-1:0] ok, input logic ie);
        int n;
        if (ho || ie) exp_q.push_back('{ie, ok});
        @(negedge clk);
        n = 0;
        while (!cmd_ready_v[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_op  = op;
        cmd_key = key;
        cmd_valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_v[sel] = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (cmd_ready_v[sel]) break;
            n++;
        end
        #1;
        check("op_ready_timeout", int'(n < 50), 1);
        check("sb_missing_output", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_state(input int cnt, input logic [W-1:0] top);
        int depth;
        depth = (sel == 2) ? 4 : 7;
        check("count", int'(count_v[sel]), cnt);
        check("empty", int'(empty_v[sel]), int'(cnt == 0));
        check("full", int'(full_v[sel]), int'(cnt == depth));
        check("top_valid", int'(top_valid_v[sel]), int'(cnt != 0));
        if (cnt != 0) check("top_key", int'(top_key_v[sel]), int'(top));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cmd_valid_v = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_random(input int d, input int nops);
        logic [W-1:0] model[$];
        sel = d;
        for (int k = 0; k < nops; k++) begin
            int           r, bi, bad;
            logic [1:0]   op;
            logic [W-1:0] key, best;
            logic         ho, ie;
            r    = $urandom_range(0, 99);
            key  = W'($urandom_range(0, 15));
            op   = (r < 45) ? PUSH : (r < 75) ? POP : (r < 97) ? REPL : CLR;
            ho   = 1'b0;
            ie   = 1'b0;
            best = '0;
            bi   = best_idx(d, model);
            case (op)
                PUSH: if (model.size() == 7) ie = 1'b1; else model.push_back(key);
                POP: begin
                    if (bi < 0) ie = 1'b1;
                    else begin
                        ho = 1'b1; best = model[bi]; model.delete(bi);
                    end
                end
                REPL: begin
                    if (bi < 0) ie = 1'b1;
                    else begin
                        ho = 1'b1; best = model[bi]; model.delete(bi); model.push_back(key);
                    end
                end
                default: model.delete();
            endcase
            do_op(op, key, ho, best, ie);
            bi = best_idx(d, model);
            check_state(model.size(), (bi < 0) ? '0 : model[bi]);
            bad = 0;
            for (int i = 1; i < model.size(); i++)
                if (tb_better(d, arr_at(d, i), arr_at(d, (i - 1) / 2))) bad = bad + 1;
            check("heap_order", bad, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        cmd_valid_v = '0;
        cmd_op      = 2'b00;
        cmd_key     = '0;
        apply_reset();
        for (int d = 0; d < 3; d++) begin
            sel = d;
            check("rst_count", int'(count_v[d]), 0);
            check("rst_ready", int'(cmd_ready_v[d]), 1);
            check("rst_out_valid", int'(out_valid_v[d]), 0);
            check("rst_out_key", int'(out_key_v[d]), 0);
            check("rst_err", int'(err_v[d]), 0);
            check("rst_empty", int'(empty_v[d]), 1);
        end

        // max ordering
        vecs.push_back(mk(0, PUSH, 8'd5, 1'b0, 8'd0, 1'b0, 1, 8'd5));
        vecs.push_back(mk(0, PUSH, 8'd3, 1'b0, 8'd0, 1'b0, 2, 8'd5));
        vecs.push_back(mk(0, PUSH, 8'd8, 1'b0, 8'd0, 1'b0, 3, 8'd8));
        vecs.push_back(mk(0, PUSH, 8'd1, 1'b0, 8'd0, 1'b0, 4, 8'd8));
        vecs.push_back(mk(0, POP,  8'd0, 1'b1, 8'd8, 1'b0, 3, 8'd5));
        vecs.push_back(mk(0, POP,  8'd0, 1'b1, 8'd5, 1'b0, 2, 8'd3));
        vecs.push_back(mk(0, POP,  8'd0, 1'b1, 8'd3, 1'b0, 1, 8'd1));
        vecs.push_back(mk(0, POP,  8'd0, 1'b1, 8'd1, 1'b0, 0, 8'd0));
        // min ordering with a duplicated key
        vecs.push_back(mk(1, PUSH, 8'd7, 1'b0, 8'd0, 1'b0, 1, 8'd7));
        vecs.push_back(mk(1, PUSH, 8'd2, 1'b0, 8'd0, 1'b0, 2, 8'd2));
        vecs.push_back(mk(1, PUSH, 8'd9, 1'b0, 8'd0, 1'b0, 3, 8'd2));
        vecs.push_back(mk(1, PUSH, 8'd2, 1'b0, 8'd0, 1'b0, 4, 8'd2));
        vecs.push_back(mk(1, POP,  8'd0, 1'b1, 8'd2, 1'b0, 3, 8'd2));
        vecs.push_back(mk(1, POP,  8'd0, 1'b1, 8'd2, 1'b0, 2, 8'd7));
        vecs.push_back(mk(1, POP,  8'd0, 1'b1, 8'd7, 1'b0, 1, 8'd9));
        vecs.push_back(mk(1, POP,  8'd0, 1'b1, 8'd9, 1'b0, 0, 8'd0));
        // full and empty rejections on the small queue
        vecs.push_back(mk(2, PUSH, 8'd10, 1'b0, 8'd0, 1'b0, 1, 8'd10));
        vecs.push_back(mk(2, PUSH, 8'd20, 1'b0, 8'd0, 1'b0, 2, 8'd20));
        vecs.push_back(mk(2, PUSH, 8'd30, 1'b0, 8'd0, 1'b0, 3, 8'd30));
        vecs.push_back(mk(2, PUSH, 8'd40, 1'b0, 8'd0, 1'b0, 4, 8'd40));
        vecs.push_back(mk(2, PUSH, 8'd50, 1'b0, 8'd0, 1'b1, 4, 8'd40));
        vecs.push_back(mk(2, CLR,  8'd0,  1'b0, 8'd0, 1'b0, 0, 8'd0));
        vecs.push_back(mk(2, POP,  8'd0,  1'b0, 8'd0, 1'b1, 0, 8'd0));
        vecs.push_back(mk(2, REPL, 8'd7,  1'b0, 8'd0, 1'b1, 0, 8'd0));
        // replace of the root pushes the new key down
        vecs.push_back(mk(0, PUSH, 8'd8, 1'b0, 8'd0, 1'b0, 1, 8'd8));
        vecs.push_back(mk(0, PUSH, 8'd5, 1'b0, 8'd0, 1'b0, 2, 8'd8));
        vecs.push_back(mk(0, PUSH, 8'd3, 1'b0, 8'd0, 1'b0, 3, 8'd8));
        vecs.push_back(mk(0, REPL, 8'd0, 1'b1, 8'd8, 1'b0, 3, 8'd5));
        vecs.push_back(mk(0, CLR,  8'd0, 1'b0, 8'd0, 1'b0, 0, 8'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].dut;
            do_op(vecs[i].op, vecs[i].key, vecs[i].has_out, vecs[i].out, vecs[i].is_err);
            check_state(vecs[i].cnt, vecs[i].top);
        end

        // reset while a pop is still sifting down
        sel = 0;
        for (int k = 9; k >= 3; k--) do_op(PUSH, W'(k), 1'b0, '0, 1'b0);
        check_state(7, 8'd9);
        @(negedge clk);
        cmd_op = POP;
        cmd_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_v[0] = 1'b0;
        check("t5_busy", int'(cmd_ready_v[0]), 0);
        reset = 1'b1;
        #1;
        check("t5_count", int'(count_v[0]), 0);
        check("t5_ready", int'(cmd_ready_v[0]), 1);
        check("t5_out_valid", int'(out_valid_v[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(PUSH, 8'd6, 1'b0, '0, 1'b0);
        check_state(1, 8'd6);

        apply_reset();
        run_random(0, 1000);
        apply_reset();
        run_random(1, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
